edge_generator: RTL and testbench

- Transmit counterpart of the edge counter: drives one FPGA output with three timed edges whose spacings come from three count registers (D1, D2, D3, in clk cycles).
- Start source is either a software enable or a trigger input chained from an edge counter or from another generator.
- Four instances sit behind a SCARF regmap, mirroring the four edge counter instances, so a measured waveform can be replayed.

---
 rtl/edge_generator_pkg.sv | 14 +
 rtl/edge_gen_timer.sv | 53 +++++
 rtl/edge_generator.sv | 137 +++++++++++++
 tb/tb_edge_generator.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_generator_pkg.sv
// Shared types and defaults for the edge generator and its interval timer.
package edge_generator_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_D1,
        WAIT_D2,
        WAIT_D3,
        DONE
    } edge_gen_state_t;

    localparam int DEFAULT_COUNT_WIDTH = 32;

endpackage

// File: rtl/edge_gen_timer.sv
// Loadable down-counter for one edge interval; a zero load runs as one cycle.
// expire is high on the cycle whose closing edge is the load edge plus N.
module edge_gen_timer
    import edge_generator_pkg::*;
#(
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_sync,
    input  logic                   load,
    input  logic                   clear,
    input  logic [COUNT_WIDTH-1:0] load_val,
    output logic                   expire
);

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   active_q, active_d;

    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (clear) begin
            cnt_d    = '0;
            active_d = 1'b0;
        end else if (load) begin
            cnt_d    = (load_val == '0) ? CNT_ONE : load_val;
            active_d = 1'b1;
        end else if (active_q) begin
            // Stop at expiry rather than wrapping, so full-scale loads are safe.
            if (cnt_q == CNT_ONE) begin
                cnt_d    = '0;
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end
    end

    assign expire = active_q && (cnt_q == CNT_ONE);

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/edge_generator.sv
// Drives gpio_out with three timed toggles after a software or chained trigger start.
// Counts and idle level are captured at start, so register writes mid-run are ignored.
module edge_generator
    import edge_generator_pkg::*;
#(
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_sync,
    input  logic                   cfg_enable,
    input  logic                   cfg_trig_enable,
    input  logic                   cfg_out_inv,
    input  logic                   cfg_trig_out,
    input  logic                   trig_in,
    input  logic [COUNT_WIDTH-1:0] d1_count,
    input  logic [COUNT_WIDTH-1:0] d2_count,
    input  logic [COUNT_WIDTH-1:0] d3_count,
    output logic                   gpio_out,
    output logic                   trig_out,
    output logic                   busy,
    output logic                   done
);

    edge_gen_state_t        state_q, state_d;
    logic                   cfg_enable_q, cfg_enable_d;
    logic [COUNT_WIDTH-1:0] d2_sh_q, d2_sh_d;
    logic [COUNT_WIDTH-1:0] d3_sh_q, d3_sh_d;
    logic                   inv_sh_q, inv_sh_d;
    logic                   gpio_q, gpio_d;
    logic                   trig_q, trig_d;

    logic                   start;
    logic                   tmr_load;
    logic                   tmr_clear;
    logic [COUNT_WIDTH-1:0] tmr_val;
    logic                   tmr_expire;

    edge_gen_timer #(
        .COUNT_WIDTH(COUNT_WIDTH)
    ) u_timer (
        .clk      (clk),
        .rst_sync (rst_sync),
        .load     (tmr_load),
        .clear    (tmr_clear),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    assign start = cfg_enable & (cfg_trig_enable ? trig_in : ~cfg_enable_q);

    always_comb begin
        state_d      = state_q;
        cfg_enable_d = cfg_enable;
        d2_sh_d      = d2_sh_q;
        d3_sh_d      = d3_sh_q;
        inv_sh_d     = inv_sh_q;
        gpio_d       = gpio_q;
        trig_d       = 1'b0;
        tmr_load     = 1'b0;
        tmr_clear    = 1'b0;
        tmr_val      = d1_count;

        unique case (state_q)
            IDLE: begin
                gpio_d = cfg_out_inv;
                if (start) begin
                    d2_sh_d  = d2_count;
                    d3_sh_d  = d3_count;
                    inv_sh_d = cfg_out_inv;
                    tmr_load = 1'b1;
                    tmr_val  = d1_count;
                    trig_d   = ~cfg_trig_out;
                    state_d  = WAIT_D1;
                end
            end
            WAIT_D1, WAIT_D2, WAIT_D3: begin
                if (!cfg_enable) begin
                    tmr_clear = 1'b1;
                    gpio_d    = cfg_out_inv;
                    state_d   = IDLE;
                end else if (tmr_expire) begin
                    gpio_d = ~gpio_q;
                    if (state_q == WAIT_D1) begin
                        tmr_load = 1'b1;
                        tmr_val  = d2_sh_q;
                        state_d  = WAIT_D2;
                    end else if (state_q == WAIT_D2) begin
                        tmr_load = 1'b1;
                        tmr_val  = d3_sh_q;
                        state_d  = WAIT_D3;
                    end else begin
                        trig_d  = cfg_trig_out;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // One-shot: only dropping cfg_enable re-arms the generator.
                gpio_d = ~inv_sh_q;
                if (!cfg_enable) begin
                    gpio_d  = cfg_out_inv;
                    state_d = IDLE;
                end
            end
            default: begin
                gpio_d  = cfg_out_inv;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state_q      <= IDLE;
            cfg_enable_q <= 1'b0;
            d2_sh_q      <= '0;
            d3_sh_q      <= '0;
            inv_sh_q     <= 1'b0;
            gpio_q       <= 1'b0;
            trig_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cfg_enable_q <= cfg_enable_d;
            d2_sh_q      <= d2_sh_d;
            d3_sh_q      <= d3_sh_d;
            inv_sh_q     <= inv_sh_d;
            gpio_q       <= gpio_d;
            trig_q       <= trig_d;
        end
    end

    assign gpio_out = gpio_q;
    assign trig_out = trig_q;
    assign busy     = (state_q == WAIT_D1) || (state_q == WAIT_D2) || (state_q == WAIT_D3);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_edge_generator.sv
// Scoreboard bench: an edge-time model predicts outputs every cycle; a monitor compares them.
module tb_edge_generator;

    logic        clk = 1'b0;
    logic        rst_sync;
    logic        cfg_enable;
    logic        cfg_trig_enable;
    logic        cfg_out_inv;
    logic        cfg_trig_out;
    logic        trig_in;
    logic [31:0] d1_count;
    logic [31:0] d2_count;
    logic [31:0] d3_count;
    logic        gpio_out;
    logic        trig_out;
    logic        busy;
    logic        done;

    edge_generator #(.COUNT_WIDTH(32)) dut (
        .clk             (clk),
        .rst_sync        (rst_sync),
        .cfg_enable      (cfg_enable),
        .cfg_trig_enable (cfg_trig_enable),
        .cfg_out_inv     (cfg_out_inv),
        .cfg_trig_out    (cfg_trig_out),
        .trig_in         (trig_in),
        .d1_count        (d1_count),
        .d2_count        (d2_count),
        .d3_count        (d3_count),
        .gpio_out        (gpio_out),
        .trig_out        (trig_out),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic gpio;
        logic trig;
        logic busy;
        logic done;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    // Model: a run is described only by its start cycle and three absolute edge times.
    longint cyc = 0;
    longint t1, t2, t3;
    int     m_mode = M_IDLE;
    int     n_past;
    logic   m_l, m_gpio, m_trig, m_en_prev;

    function automatic longint clamp(logic [31:0] v);
        return (v == 32'd0) ? 64'd1 : longint'(v);
    endfunction

    always @(posedge clk) begin
        cyc++;
        m_trig = 1'b0;
        if (rst_sync) begin
            m_mode    = M_IDLE;
            m_gpio    = 1'b0;
            m_en_prev = 1'b0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    m_gpio = cfg_out_inv;
                    if (cfg_enable && (cfg_trig_enable ? trig_in : !m_en_prev)) begin
                        t1     = cyc + clamp(d1_count);
                        t2     = t1 + clamp(d2_count);
                        t3     = t2 + clamp(d3_count);
                        m_l    = cfg_out_inv;
                        m_mode = M_RUN;
                        m_trig = !cfg_trig_out;
                    end
                end
                M_RUN: begin
                    if (!cfg_enable) begin
                        m_mode = M_IDLE;
                        m_gpio = cfg_out_inv;
                    end else begin
                        n_past = int'(cyc >= t1) + int'(cyc >= t2) + int'(cyc >= t3);
                        m_gpio = m_l ^ n_past[0];
                        if (n_past == 3) begin
                            m_mode = M_DONE;
                            m_trig = cfg_trig_out;
                        end
                    end
                end
                default: begin
                    if (!cfg_enable) begin
                        m_mode = M_IDLE;
                        m_gpio = cfg_out_inv;
                    end else begin
                        m_gpio = !m_l;
                    end
                end
            endcase
            m_en_prev = cfg_enable;
        end
        exp_q.push_back('{m_gpio, m_trig, m_mode == M_RUN, m_mode == M_DONE});
    end

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%b expected=%b", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty cycle=%0d actual=0 entries expected=1", cyc);
        end else begin
            e = exp_q.pop_front();
            chk("gpio_out", gpio_out, e.gpio);
            chk("trig_out", trig_out, e.trig);
            chk("busy", busy, e.busy);
            chk("done", done, e.done);
            checks++;
            if (busy && done) begin
                failures++;
                $display("FAIL busy_done_exclusive cycle=%0d actual=11 expected=not both", cyc);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_counts(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        d1_count = a;
        d2_count = b;
        d3_count = c;
    endtask

    initial begin
        rst_sync        = 1'b1;
        cfg_enable      = 1'b0;
        cfg_trig_enable = 1'b0;
        cfg_out_inv     = 1'b0;
        cfg_trig_out    = 1'b0;
        trig_in         = 1'b0;
        set_counts(32'd0, 32'd0, 32'd0);
        step(3);
        rst_sync = 1'b0;
        step(2);

        // Software start, idle low.
        set_counts(32'd5, 32'd3, 32'd10);
        cfg_enable = 1'b1;
        step(25);
        cfg_enable = 1'b0;
        step(3);

        // Chained trigger start, idle high, trig_out at third edge, retrigger ignored.
        cfg_trig_enable = 1'b1;
        cfg_trig_out    = 1'b1;
        cfg_out_inv     = 1'b1;
        set_counts(32'd1, 32'd1, 32'd1);
        cfg_enable = 1'b1;
        step(2);
        trig_in = 1'b1;
        step(1);
        trig_in = 1'b0;
        step(5);
        trig_in = 1'b1;
        step(1);
        trig_in = 1'b0;
        step(5);
        cfg_enable = 1'b0;
        step(3);

        // Zero counts clamp to one cycle.
        cfg_trig_enable = 1'b0;
        cfg_trig_out    = 1'b0;
        cfg_out_inv     = 1'b0;
        set_counts(32'd0, 32'd0, 32'd2);
        cfg_enable = 1'b1;
        step(10);
        cfg_enable = 1'b0;
        step(2);

        // Abort during a long first interval.
        set_counts(32'd100, 32'd5, 32'd5);
        cfg_enable = 1'b1;
        step(40);
        cfg_enable = 1'b0;
        step(70);

        // Mid-run count write must not affect the run.
        set_counts(32'd4, 32'd20, 32'd3);
        cfg_enable = 1'b1;
        step(2);
        d2_count = 32'd3;
        step(40);
        cfg_enable = 1'b0;
        step(2);

        // Reset mid-run with enable held: fresh start after release.
        set_counts(32'd10, 32'd10, 32'd10);
        cfg_enable = 1'b1;
        step(15);
        rst_sync = 1'b1;
        step(2);
        rst_sync = 1'b0;
        step(40);
        cfg_enable = 1'b0;
        step(2);

        // Full-scale first interval, then abort.
        set_counts(32'hFFFF_FFFF, 32'd1, 32'd1);
        cfg_enable = 1'b1;
        step(20);
        cfg_enable = 1'b0;
        step(2);

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            cfg_trig_enable = 1'($urandom_range(0, 1));
            cfg_out_inv     = 1'($urandom_range(0, 1));
            cfg_trig_out    = 1'($urandom_range(0, 1));
            trig_in         = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0)
                cfg_enable = ~cfg_enable;
            if ($urandom_range(0, 2) == 0)
                set_counts(32'($urandom_range(0, 12)), 32'($urandom_range(0, 12)),
                           32'($urandom_range(0, 12)));
            rst_sync = ($urandom_range(0, 60) == 0);
            step($urandom_range(1, 8));
            rst_sync = 1'b0;
        end

        cfg_enable = 1'b0;
        trig_in    = 1'b0;
        step(3);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
